// File: rtl/ascii_uart_rx_if.sv
// ascii_uart_rx_if -- result bundle of the ASCII UART receiver.
//   char_out : last accepted 7-bit character (bit 0 = D0 of the segment decoder)
//   valid    : one-cycle pulse when char_out updates
//   err      : one-cycle pulse on a rejected frame
//   busy     : high while a frame is in progress
// master = the receiver (drives), slave = the consumer (observes).
interface ascii_uart_rx_if;
  logic [6:0] char_out;
  logic       valid;
  logic       err;
  logic       busy;

  modport master (output char_out, valid, err, busy);
  modport slave  (input  char_out, valid, err, busy);
endinterface

// File: rtl/ascii_uart_rx.sv
// ascii_uart_rx -- 8N1 serial receiver feeding a 7-bit ASCII segment decoder.
//   clk   : single clock for all state
//   rst_n : asynchronous active-low reset
//   rx    : asynchronous serial line, idles high
//   out   : ascii_uart_rx_if.master (char_out / valid / err / busy)
// Parameter CLKS_PER_BIT (4..4095): clk cycles per serial bit.
// Optional feature: define ASCII_UART_RX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (8E1 framing).
module ascii_uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  ascii_uart_rx_if.master out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Start detection waits half a bit so every later sample lands mid-bit.
  localparam logic [11:0] HALF_RELOAD = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] FULL_RELOAD = 12'(CLKS_PER_BIT - 1);

  logic [1:0]  sync_q;
  logic        rx_s;
  logic [2:0]  state;
  logic [11:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [6:0]  char_q;
  logic        valid_q;
  logic        err_q;
  logic        cnt_zero;
  logic        frame_ok;
`ifdef ASCII_UART_RX_PARITY_EN
  logic        par_bad;
`endif

  // Synchronizer resets to the idle level so reset release never looks
  // like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rx_s     = sync_q[1];
  assign cnt_zero = (cnt == 12'd0);

`ifdef ASCII_UART_RX_PARITY_EN
  assign frame_ok = rx_s && !par_bad;
`else
  assign frame_ok = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 12'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      char_q  <= 7'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ASCII_UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      // Result strobes are single-cycle; they are only set on STOP -> DONE.
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt     <= HALF_RELOAD;
            bit_idx <= 3'd0;
            state   <= S_START;
`ifdef ASCII_UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end

        S_START: begin
          if (!cnt_zero) begin
            cnt <= cnt - 12'd1;
          end else if (!rx_s) begin
            cnt   <= FULL_RELOAD;
            state <= S_DATA;
          end else begin
            // Line back high at mid start bit: a glitch, dropped silently.
            state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - 12'd1;
          end else begin
            // LSB arrives first, so shift right and insert at the top.
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FULL_RELOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef ASCII_UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end

`ifdef ASCII_UART_RX_PARITY_EN
        S_PARITY: begin
          if (!cnt_zero) begin
            cnt <= cnt - 12'd1;
          end else begin
            // Even parity: data bits plus parity bit must XOR to zero.
            par_bad <= (^shreg) ^ rx_s;
            cnt     <= FULL_RELOAD;
            state   <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (!cnt_zero) begin
            cnt <= cnt - 12'd1;
          end else begin
            state <= S_DONE;
            if (frame_ok) begin
              valid_q <= 1'b1;
              // Codes above 7'h7F have no glyph; show them as blank.
              char_q  <= shreg[7] ? 7'h00 : shreg[6:0];
            end else begin
              err_q   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // One-cycle hold so the next start edge is only seen from IDLE.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign out.char_out = char_q;
  assign out.valid    = valid_q;
  assign out.err      = err_q;
  assign out.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_ascii_uart_rx.sv
module tb_ascii_uart_rx;
  localparam int CPB = 16;

  typedef struct packed {
    logic       e;
    logic [6:0] c;
  } ev_t;

  logic clk;
  logic rst_n;
  logic rx;
  ascii_uart_rx_if bus ();

  ascii_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .out   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  both_cnt = 0;
  int  wide_cnt = 0;
  logic pv = 1'b0, pe = 1'b0, pend = 1'b0;
  logic busy_at_pulse = 1'b0, busy_after = 1'b1;
`ifdef ASCII_UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  // Monitor: records every result pulse and pulse-shape anomalies.
  always @(negedge clk) begin
    if (pend) begin
      busy_after = bus.busy;
      pend = 1'b0;
    end
    if (bus.valid || bus.err) begin
      obs_q.push_back('{e: bus.err, c: bus.char_out});
      busy_at_pulse = bus.busy;
      pend = 1'b1;
    end
    if (bus.valid && bus.err) both_cnt++;
    if ((bus.valid && pv) || (bus.err && pe)) wide_cnt++;
    pv = bus.valid;
    pe = bus.err;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef ASCII_UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.char_out !== 7'h00) begin n_bad++; $display("FAIL reset_char got=%h want=00", bus.char_out); end
    n_cmp++; if ({bus.valid, bus.err, bus.busy} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b want=000", {bus.valid, bus.err, bus.busy}); end
    n_cmp++; if (dut.sync_q !== 2'b11) begin n_bad++; $display("FAIL reset_sync got=%b want=11", dut.sync_q); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame;
    ev_t o, x;
    exp_q.push_back('{e: 1'b0, c: 7'h41});
    send_frame(8'h41, 1'b1);
    for (int i = 0; i < 40 && obs_q.size() < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL good_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_cmp++; if (o !== x) begin n_bad++; $display("FAIL good_event got=%h want=%h", o, x); end
    end
    n_cmp++; if (busy_at_pulse !== 1'b1) begin n_bad++; $display("FAIL good_busy_done got=%b want=1", busy_at_pulse); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL good_busy_after got=%b want=0", busy_after); end
    n_cmp++; if (bus.char_out !== 7'h41) begin n_bad++; $display("FAIL good_char got=%h want=41", bus.char_out); end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high got=%b want=1", bus.busy); end
    rx = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle got=%b want=0", bus.busy); end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL glitch_pulses got=%0d want=0", obs_q.size()); end
    n_cmp++; if (bus.char_out !== 7'h41) begin n_bad++; $display("FAIL glitch_char got=%h want=41", bus.char_out); end
  endtask

  task automatic test_stop_error;
    ev_t o, x;
    exp_q.push_back('{e: 1'b0, c: 7'h33});
    send_frame(8'h33, 1'b1);
    exp_q.push_back('{e: 1'b1, c: 7'h33});
    send_frame(8'h5A, 1'b0);
    for (int i = 0; i < 40 && obs_q.size() < 2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 2) begin n_bad++; $display("FAIL stoperr_count got=%0d want=2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_cmp++; if (o !== x) begin n_bad++; $display("FAIL stoperr_event got=%h want=%h", o, x); end
    end
    n_cmp++; if (bus.char_out !== 7'h33) begin n_bad++; $display("FAIL stoperr_char got=%h want=33", bus.char_out); end
  endtask

  task automatic test_high_bit;
    ev_t o, x;
    exp_q.push_back('{e: 1'b0, c: 7'h00});
    send_frame(8'hC1, 1'b1);
    for (int i = 0; i < 40 && obs_q.size() < 1; i++) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL highbit_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_cmp++; if (o !== x) begin n_bad++; $display("FAIL highbit_event got=%h want=%h", o, x); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    ev_t o, x;
    logic [7:0] d;
    d  = 8'h55;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[3];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL midrst_pulses got=%0d want=0", obs_q.size()); end
    n_cmp++; if (bus.char_out !== 7'h00) begin n_bad++; $display("FAIL midrst_char got=%h want=00", bus.char_out); end
    exp_q.push_back('{e: 1'b0, c: 7'h30});
    send_frame(8'h30, 1'b1);
    for (int i = 0; i < 40 && obs_q.size() < 1; i++) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL midrst_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_cmp++; if (o !== x) begin n_bad++; $display("FAIL midrst_event got=%h want=%h", o, x); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    ev_t o, x;
    logic [7:0] msg [4];
    msg = '{8'h48, 8'h69, 8'h21, 8'h7F};
    foreach (msg[k]) begin
      exp_q.push_back('{e: 1'b0, c: msg[k][6:0]});
      send_frame(msg[k], 1'b1);
    end
    for (int i = 0; i < 40 && obs_q.size() < 4; i++) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 4) begin n_bad++; $display("FAIL b2b_count got=%0d want=4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_cmp++; if (o !== x) begin n_bad++; $display("FAIL b2b_event got=%h want=%h", o, x); end
    end
    repeat (4) @(negedge clk);
  endtask

`ifdef ASCII_UART_RX_PARITY_EN
  // 0x41 has an even number of ones, so parity bit 0 is the good one.
  task automatic test_parity;
    ev_t o, x;
    par_flip = 1'b1;
    exp_q.push_back('{e: 1'b1, c: bus.char_out});
    send_frame(8'h41, 1'b1);
    par_flip = 1'b0;
    exp_q.push_back('{e: 1'b0, c: 7'h41});
    send_frame(8'h41, 1'b1);
    for (int i = 0; i < 40 && obs_q.size() < 2; i++) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 2) begin n_bad++; $display("FAIL parity_count got=%0d want=2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_cmp++; if (o !== x) begin n_bad++; $display("FAIL parity_event got=%h want=%h", o, x); end
    end
    repeat (4) @(negedge clk);
  endtask
`endif

  task automatic test_pulse_shape;
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL pulse_overlap got=%0d want=0", both_cnt); end
    n_cmp++; if (wide_cnt !== 0) begin n_bad++; $display("FAIL pulse_width got=%0d want=0", wide_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_stop_error();
    test_high_bit();
    test_reset_midframe();
    test_back_to_back();
`ifdef ASCII_UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
